// File: rtl/seq_mult_n.sv
// seq_mult_n: sequential shift-add multiplier, one partial product per clock.
// Operands are captured when a rising edge of 'start' is accepted in IDLE.
// After WIDTH iterations, 'product' holds {A,B} and 'done' pulses for one cycle.
// Two's-complement operation uses a (WIDTH+1)-bit accumulator {X,A}.
// The sign extension bit X keeps most-negative * most-negative in range.
// Optional feature: define UNSIGNED_MODE_EN to add the 'is_signed' port.
// With is_signed low, the operands are treated as unsigned.
module seq_mult_n #(
  parameter int WIDTH = 8
) (
  input  logic                 Clk,
  input  logic                 Reset_Load_Clear_SH,
  input  logic                 start,
  input  logic [WIDTH-1:0]     multiplicand,
  input  logic [WIDTH-1:0]     multiplier,
`ifdef UNSIGNED_MODE_EN
  input  logic                 is_signed,
`endif
  output logic                 busy,
  output logic                 done,
  output logic [2*WIDTH-1:0]   product,
  output logic                 x_out
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t           state, state_next;
  logic             start_prev;
  logic             start_rise;
  logic [WIDTH-1:0] s_reg, a_reg, b_reg;
  logic             x_reg;
  logic [CW-1:0]    count;
  logic             sgn;

  // Per-iteration datapath values
  logic             ext_a, ext_s;
  logic [WIDTH:0]   addend, sum;
  logic             x_sum;
  logic [WIDTH-1:0] a_sum;
  logic             x_step;
  logic [WIDTH-1:0] a_step, b_step;

  assign start_rise = start & ~start_prev;
  assign x_out      = x_reg;

`ifdef UNSIGNED_MODE_EN
  logic sgn_reg;

  // Capture signedness together with the operands so mid-operation changes are ignored
  always_ff @(posedge Clk or posedge Reset_Load_Clear_SH) begin
    if (Reset_Load_Clear_SH)                sgn_reg <= 1'b0;
    else if (state == IDLE && start_rise)   sgn_reg <= is_signed;
  end
  assign sgn = sgn_reg;
`else
  assign sgn = 1'b1;
`endif

  // One iteration: conditional add or subtract into {X,A}, then shift {X,A,B} right by one
  always_comb begin
    // NOTE: every signal assigned in a combinational block gets a value on every path; otherwise a latch is inferred.
    ext_a  = sgn & a_reg[WIDTH-1];
    ext_s  = sgn & s_reg[WIDTH-1];
    addend = {ext_s, s_reg};
    sum    = {ext_a, a_reg} + addend;
    // The last iteration has the multiplier sign bit, which has weight -2^(N-1).
    if (sgn && count == LAST) sum = {ext_a, a_reg} - addend;
    {x_sum, a_sum} = {x_reg, a_reg};
    if (b_reg[0]) {x_sum, a_sum} = sum;
    // Signed mode: X keeps the sign (arithmetic shift). Unsigned mode: the carry shifts out.
    x_step = sgn ? x_sum : 1'b0;
    a_step = {x_sum, a_sum[WIDTH-1:1]};
    b_step = {a_sum[0], b_reg[WIDTH-1:1]};
  end

  // Edge-detect history for start, sampled every clock
  always_ff @(posedge Clk or posedge Reset_Load_Clear_SH) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    if (Reset_Load_Clear_SH) start_prev <= 1'b0;
    else                     start_prev <= start;
  end

  // Datapath registers: load on accept, iterate in CALC, capture result on final iteration
  always_ff @(posedge Clk or posedge Reset_Load_Clear_SH) begin
    if (Reset_Load_Clear_SH) begin
      s_reg   <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      x_reg   <= 1'b0;
      count   <= '0;
      product <= '0;
    end else if (state == IDLE && start_rise) begin
      s_reg <= multiplicand;
      b_reg <= multiplier;
      a_reg <= '0;
      x_reg <= 1'b0;
      count <= '0;
    end else if (state == CALC) begin
      x_reg <= x_step;
      a_reg <= a_step;
      b_reg <= b_step;
      count <= count + 1'b1;
      // product is ready in the same cycle that done pulses
      if (count == LAST) product <= {a_step, b_step};
    end
  end

  // FSM state register
  always_ff @(posedge Clk or posedge Reset_Load_Clear_SH) begin
    if (Reset_Load_Clear_SH) state <= IDLE;
    else                     state <= state_next;
  end

  // FSM next-state logic; a start edge seen in CALC or DONE is dropped, not queued
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (start_rise) state_next = CALC;
      CALC:    if (count == LAST) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs, decoded from the current state
  always_comb begin
    busy = (state == CALC);
    done = (state == DONE);
  end

endmodule

// File: tb/tb_seq_mult_n.sv
// tb_seq_mult_n: directed checks of seq_mult_n with WIDTH=8, plus one WIDTH=16 case.
// Covers reset values, signed products, latency, start edge handling, and abort on reset.
// The unsigned cases run only when UNSIGNED_MODE_EN is defined.
module tb_seq_mult_n;

  logic        Clk = 1'b0;
  logic        Reset_Load_Clear_SH = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  multiplicand = '0;
  logic [7:0]  multiplier = '0;
  logic        busy, done, x_out;
  logic [15:0] product;

  logic        start16 = 1'b0;
  logic [15:0] mcand16 = '0;
  logic [15:0] mplier16 = '0;
  logic        busy16, done16, x_out16;
  logic [31:0] product16;

`ifdef UNSIGNED_MODE_EN
  logic is_signed = 1'b1;
`endif

  int tests  = 0;
  int failed = 0;
  int lat;
  int n;

  always #5 Clk = ~Clk;

  seq_mult_n #(.WIDTH(8)) dut (
    .Clk                 (Clk),
    .Reset_Load_Clear_SH (Reset_Load_Clear_SH),
    .start               (start),
    .multiplicand        (multiplicand),
    .multiplier          (multiplier),
`ifdef UNSIGNED_MODE_EN
    .is_signed           (is_signed),
`endif
    .busy                (busy),
    .done                (done),
    .product             (product),
    .x_out               (x_out)
  );

  seq_mult_n #(.WIDTH(16)) dut16 (
    .Clk                 (Clk),
    .Reset_Load_Clear_SH (Reset_Load_Clear_SH),
    .start               (start16),
    .multiplicand        (mcand16),
    .multiplier          (mplier16),
`ifdef UNSIGNED_MODE_EN
    .is_signed           (1'b1),
`endif
    .busy                (busy16),
    .done                (done16),
    .product             (product16),
    .x_out               (x_out16)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One operation from a single-cycle start pulse.
  // Expect done 8 edges after the accept edge and a one-cycle pulse.
  task automatic run_op(input string tag, input logic [7:0] s, input logic [7:0] m,
                        input logic [15:0] exp);
    @(negedge Clk);
    multiplicand = s;
    multiplier   = m;
    start        = 1'b1;
    @(posedge Clk);
    #1 check({tag, " busy"}, 32'(busy), 32'd1);
    @(negedge Clk);
    start        = 1'b0;
    multiplicand = ~s;
    multiplier   = ~m;
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge Clk);
      #1;
      if (done) begin
        lat = i;
        break;
      end
    end
    check({tag, " latency"}, 32'(lat), 32'd8);
    check({tag, " product"}, 32'(product), 32'(exp));
    @(posedge Clk);
    #1 check({tag, " pulse end"}, {29'd0, done, busy, 1'b0}, 32'd0);
    check({tag, " held"}, 32'(product), 32'(exp));
  endtask

  initial begin
    // Reset state
    #12;
    check("reset outs", {16'd0, product}, 32'd0);
    check("reset flags", {29'd0, busy, done, x_out}, 32'd0);
    @(negedge Clk);
    Reset_Load_Clear_SH = 1'b0;

    // Signed products
    run_op("7*3",     8'h07, 8'h03, 16'h0015);
    run_op("-3*5",    8'hFD, 8'h05, 16'hFFF1);
    check("-3*5 x_out", 32'(x_out), 32'd1);
    run_op("5*-3",    8'h05, 8'hFD, 16'hFFF1);
    run_op("-1*-1",   8'hFF, 8'hFF, 16'h0001);
    run_op("min*min", 8'h80, 8'h80, 16'h4000);
    check("min*min x_out", 32'(x_out), 32'd0);
    run_op("max*min", 8'h7F, 8'h80, 16'hC080);
    run_op("max*max", 8'h7F, 8'h7F, 16'h3F01);
    run_op("min*1",   8'h80, 8'h01, 16'hFF80);
    run_op("0*AB",    8'h00, 8'hAB, 16'h0000);

    // Start held high for 40 cycles: one operation; operand change mid-way has no effect
    @(negedge Clk);
    multiplicand = 8'h07;
    multiplier   = 8'h03;
    start        = 1'b1;
    n = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge Clk);
      #1;
      if (done) n++;
      if (i == 2) multiplicand = 8'h55;
    end
    check("held start dones", 32'(n), 32'd1);
    check("held start product", 32'(product), 32'h0015);
    @(negedge Clk);
    start = 1'b0;

    // A second start edge during CALC is ignored
    @(negedge Clk);
    multiplicand = 8'h09;
    multiplier   = 8'h09;
    start        = 1'b1;
    @(negedge Clk);
    start = 1'b0;
    @(negedge Clk);
    start        = 1'b1;
    multiplicand = 8'h02;
    @(negedge Clk);
    start = 1'b0;
    n = 0;
    for (int i = 0; i < 25; i++) begin
      @(posedge Clk);
      #1;
      if (done) n++;
    end
    check("restart dones", 32'(n), 32'd1);
    check("restart product", 32'(product), 32'h0051);

    // Reset during CALC aborts: outputs clear, no done pulse
    @(negedge Clk);
    multiplicand = 8'h07;
    multiplier   = 8'h03;
    start        = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start = 1'b0;
    repeat (4) @(posedge Clk);
    #2 Reset_Load_Clear_SH = 1'b1;
    @(posedge Clk);
    #1;
    check("abort product", 32'(product), 32'd0);
    check("abort flags", {29'd0, busy, done, x_out}, 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge Clk);
      #1;
      if (done) n++;
    end
    check("abort no done", 32'(n), 32'd0);
    @(negedge Clk);
    Reset_Load_Clear_SH = 1'b0;
    run_op("after abort", 8'h07, 8'h03, 16'h0015);

`ifdef UNSIGNED_MODE_EN
    is_signed = 1'b0;
    run_op("u FF*FF", 8'hFF, 8'hFF, 16'hFE01);
    run_op("u FF*02", 8'hFF, 8'h02, 16'h01FE);
    is_signed = 1'b1;
    run_op("s FF*02", 8'hFF, 8'h02, 16'hFFFE);
`endif

    // WIDTH=16: most-negative squared; done is expected 16 edges after accept
    @(negedge Clk);
    mcand16  = 16'h8000;
    mplier16 = 16'h8000;
    start16  = 1'b1;
    @(posedge Clk);
    @(negedge Clk);
    start16 = 1'b0;
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge Clk);
      #1;
      if (done16) begin
        lat = i;
        break;
      end
    end
    check("w16 latency", 32'(lat), 32'd16);
    check("w16 min*min", product16, 32'h40000000);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
